// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the word-serial wide adder: FSM states and
// default geometry (16-bit slice, four words per operand).
package wide_add_seq_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int NWORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_lf_add16.sv
// Combinational 16-bit Ladner-Fischer prefix adder. Generate/propagate
// pairs are combined in log2(16)=4 levels; carry-in enters at the end as
// the group-generate of the virtual bit -1.
module lf_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    localparam int N  = 16;
    localparam int LV = 4;

    logic [N-1:0] g0;
    logic [N-1:0] p0;
    logic [N-1:0] pre_g;
    logic [N-1:0] pre_p;
    logic [N:0]   carry;

    // Prefix tree: at level l, every bit whose l-th index bit is set absorbs
    // the group ending just below its 2^l-aligned block.
    always_comb begin
        logic [N-1:0] g_cur;
        logic [N-1:0] p_cur;
        logic [N-1:0] g_nxt;
        logic [N-1:0] p_nxt;
        int           j;
        g_cur = g0;
        p_cur = p0;
        g_nxt = g0;
        p_nxt = p0;
        j     = 0;
        for (int l = 0; l < LV; l++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 0; i < N; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j = ((i >> l) << l) - 1;
                    g_nxt[4'(i)] = g_cur[4'(i)] | (p_cur[4'(i)] & g_cur[4'(j)]);
                    p_nxt[4'(i)] = p_cur[4'(i)] & p_cur[4'(j)];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        pre_g = g_cur;
        pre_p = p_cur;
    end

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign g0[gi]      = a[gi] & b[gi];
            assign p0[gi]      = a[gi] ^ b[gi];
            assign carry[gi+1] = pre_g[gi] | (pre_p[gi] & cin);
            assign sum[gi]     = p0[gi] ^ carry[gi];
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder/subtractor: one 16-bit prefix-adder slice is
// time-shared over NWORDS cycles, with a registered carry between words.
// Results land in an internal accumulator and are published atomically.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NWORDS*WORD_W-1:0] a,
    input  logic [NWORDS*WORD_W-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     busy,
    output logic                     done,
    output logic [NWORDS*WORD_W-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int OPW = NWORDS * WORD_W;
    localparam int KW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t              state_reg;
    state_t              state_next;
    logic [OPW-1:0]      a_reg;
    logic [OPW-1:0]      b_reg;
    logic [OPW-1:0]      acc_reg;
    logic [OPW-1:0]      acc_next;
    logic [OPW-1:0]      sum_reg;
    logic                carry_reg;
    logic                cout_reg;
    logic                ovf_reg;
    logic [KW-1:0]       k_reg;
    logic                last_word;

    logic [WORD_W-1:0]   a_words [NWORDS];
    logic [WORD_W-1:0]   b_words [NWORDS];
    logic [WORD_W-1:0]   slice_a;
    logic [WORD_W-1:0]   slice_b;
    logic [WORD_W-1:0]   slice_sum;
    logic                slice_cout;

    // Split latched operands into words; merge the current slice result
    // into the accumulator image that becomes the published sum.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            assign a_words[gi] = a_reg[gi*WORD_W +: WORD_W];
            assign b_words[gi] = b_reg[gi*WORD_W +: WORD_W];
            assign acc_next[gi*WORD_W +: WORD_W] =
                (k_reg == KW'(gi)) ? slice_sum : acc_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign slice_a   = a_words[k_reg];
    assign slice_b   = b_words[k_reg];
    assign last_word = (k_reg == KW'(NWORDS - 1));

    lf_add16 u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status decode; start only matters in IDLE.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, word-serial accumulation and atomic result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            k_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        acc_reg   <= '0;
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= slice_cout;
                    k_reg     <= k_reg + 1'b1;
                    if (last_word) begin
                        sum_reg  <= acc_next;
                        cout_reg <= slice_cout;
                        // Signed overflow: operands agree in sign, result differs.
                        ovf_reg  <= (a_reg[OPW-1] == b_reg[OPW-1]) &&
                                    (slice_sum[WORD_W-1] != a_reg[OPW-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboarded bench for wide_add_seq: the driver queues expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_wide_add_seq;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [63:0] last_sum = '0;

    wide_add_seq #(.NWORDS(NW), .WORD_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    // 64-bit reference: one wide addition, no word slicing.
    function automatic exp_t ref_model(input logic [63:0] ta, input logic [63:0] tb_b,
                                       input logic tc, input logic ts);
        logic [63:0] bp;
        logic        c0;
        logic [64:0] full;
        exp_t        e;
        bp     = ts ? ~tb_b : tb_b;
        c0     = ts ? 1'b1 : tc;
        full   = {1'b0, ta} + {1'b0, bp} + {64'd0, c0};
        e.s    = full[63:0];
        e.c    = full[64];
        e.o    = (ta[63] == bp[63]) && (full[63] != ta[63]);
        return e;
    endfunction

    // Monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_txn++;
                chk("sum", sum, e.s);
                chk("cout", {63'd0, cout}, {63'd0, e.c});
                chk("ovf", {63'd0, ovf}, {63'd0, e.o});
                $display("txn %0d: sum=%h cout=%0b ovf=%0b (exp %h %0b %0b)",
                         n_txn, sum, cout, ovf, e.s, e.c, e.o);
            end
        end
    end

    // Issue one operation, check latency, busy width and that sum holds
    // its previous value while words are being processed.
    task automatic issue(input logic [63:0] ta, input logic [63:0] tb_b, input logic tc,
                         input logic ts, input exp_t e, input bit disturb);
        int cyc;
        int bcyc;
        bit seen;
        @(negedge clk);
        while (busy || done) @(negedge clk);
        a = ta; b = tb_b; cin = tc; sub = ts; start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = ~tc; sub = ~ts;
        cyc = 0; bcyc = 0; seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                bcyc++;
                chk("sum_hold", sum, last_sum);
            end
            if (disturb && cyc == 2) begin
                start = 1'b1;
                a = 64'hDEAD_BEEF_0000_0001; b = 64'h0123_4567_89AB_CDEF;
            end
            if (disturb && cyc == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("latency", seen ? 64'(cyc) : 64'd0, 64'(NW + 1));
        chk("busy_cycles", 64'(bcyc), 64'(NW));
        last_sum = e.s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        issue(64'h0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, mk(64'h1111_1111_1111_1111, 1'b0, 1'b0), 1'b0);
        issue('1, '1, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0), 1'b0);
        issue('1, '1, 1'b0, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0), 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b0);
        issue(64'd5, 64'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 1'b0);
        issue(64'd5, 64'd7, 1'b1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 1'b0);
        issue(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h0000_FFFF_0001_0000, 1'b0, 1'b0), 1'b0);
        issue(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h0001_0000_0000_0000, 1'b0, 1'b0), 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1), 1'b0);
        issue(64'h0, 64'h0, 1'b0, 1'b1, mk(64'h0, 1'b1, 1'b0), 1'b0);

        // Start pulsed mid-run with other operands must be ignored.
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
              mk(64'h2345_6789_ABCD_F001, 1'b0, 1'b0), 1'b1);
        repeat (8) @(negedge clk);

        // Reset two cycles into RUN aborts without a done pulse.
        a = 64'h0F0F_0F0F_0F0F_0F0F; b = 64'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_sum", sum, 64'd0);
        chk("abort_cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;
        last_sum = '0;
        repeat (8) @(negedge clk);

        // Reset and start together: reset wins.
        a = 64'h5; b = 64'h6; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", {63'd0, busy}, 64'd0);

        issue(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0011, 1'b1, 1'b0,
              mk(64'h0123_4567_89AB_CE01, 1'b0, 1'b0), 1'b0);

        // Back-to-back random operations against the wide reference.
        for (int i = 0; i < 20; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rc;
            logic        rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, rs, ref_model(ra, rb, rc, rs), 1'b0);
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
